// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard/forwarding control unit.
package hazard_pkg;

    localparam logic [2:0] FWD_RF      = 3'b000;
    localparam logic [2:0] FWD_EX_ALU  = 3'b010;
    localparam logic [2:0] FWD_MEM_ALU = 3'b100;
    localparam logic [2:0] FWD_WB_ALU  = 3'b110;
    localparam logic [2:0] FWD_WB_MEM  = 3'b111;

    localparam logic [1:0] WBSEL_MEM = 2'h1;

    typedef enum logic {
        ST_RUN,
        ST_FREEZE
    } state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: nearest producing stage wins; loads still in EX/MEM
// cannot forward and raise a load-use stall request instead.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic            used,
    input  logic            ex_regwr,
    input  logic [1:0]      ex_wbsel,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_regwr,
    input  logic [1:0]      mem_wbsel,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_regwr,
    input  logic [1:0]      wb_wbsel,
    input  logic [RA_W-1:0] wb_rd,
    output logic [2:0]      sel,
    output logic            lu_req
);

    logic active;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign active  = used && (rs != '0);
    assign ex_hit  = active && ex_regwr && (ex_rd == rs);
    assign mem_hit = active && mem_regwr && (mem_rd == rs);
    assign wb_hit  = active && wb_regwr && (wb_rd == rs);

    always_comb begin
        sel    = FWD_RF;
        lu_req = 1'b0;
        if (ex_hit) begin
            if (ex_wbsel == WBSEL_MEM) lu_req = 1'b1;
            else                       sel    = FWD_EX_ALU;
        end else if (mem_hit) begin
            if (mem_wbsel == WBSEL_MEM) lu_req = 1'b1;
            else                        sel    = FWD_MEM_ALU;
        end else if (wb_hit) begin
            sel = (wb_wbsel == WBSEL_MEM) ? FWD_WB_MEM : FWD_WB_ALU;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Hazard, forwarding and pipeline-control unit: operand forwarding, load-use stalls,
// memory-busy freezes, deferred branch flushes, stall statistics and a hang watchdog.
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WDOG  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_regwr,
    input  logic             mem_regwr,
    input  logic             wb_regwr,
    input  logic [1:0]       ex_wbsel,
    input  logic [1:0]       mem_wbsel,
    input  logic [1:0]       wb_wbsel,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             mem_busy,
    input  logic             br_taken,
    output logic [2:0]       rs1val_cont,
    output logic [2:0]       rs2val_cont,
    output logic             stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             hang
);

    localparam logic [CNT_W-1:0] WdogLim = CNT_W'(WDOG);

    logic [2:0] rs1_sel;
    logic [2:0] rs2_sel;
    logic       rs1_lu;
    logic       rs2_lu;
    logic       lu;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic             hang_q, hang_d;

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_rs1 (
        .rs        (id_rs1),
        .used      (id_rs1_used),
        .ex_regwr  (ex_regwr),
        .ex_wbsel  (ex_wbsel),
        .ex_rd     (ex_rd),
        .mem_regwr (mem_regwr),
        .mem_wbsel (mem_wbsel),
        .mem_rd    (mem_rd),
        .wb_regwr  (wb_regwr),
        .wb_wbsel  (wb_wbsel),
        .wb_rd     (wb_rd),
        .sel       (rs1_sel),
        .lu_req    (rs1_lu)
    );

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_rs2 (
        .rs        (id_rs2),
        .used      (id_rs2_used),
        .ex_regwr  (ex_regwr),
        .ex_wbsel  (ex_wbsel),
        .ex_rd     (ex_rd),
        .mem_regwr (mem_regwr),
        .mem_wbsel (mem_wbsel),
        .mem_rd    (mem_rd),
        .wb_regwr  (wb_regwr),
        .wb_wbsel  (wb_wbsel),
        .wb_rd     (wb_rd),
        .sel       (rs2_sel),
        .lu_req    (rs2_lu)
    );

    assign lu = rs1_lu | rs2_lu;

    always_comb begin
        rs1val_cont  = rs1_sel;
        rs2val_cont  = rs2_sel;
        stall        = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        pend_d       = pend_q;
        state_d      = state_q;

        unique case (state_q)
            ST_RUN:    if (mem_busy)  state_d = ST_FREEZE;
            ST_FREEZE: if (!mem_busy) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        if (rst) begin
            rs1val_cont = FWD_RF;
            rs2val_cont = FWD_RF;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pend_d      = 1'b0;
            state_d     = ST_RUN;
        end else if (mem_busy) begin
            // A redirect seen while frozen is remembered until MEM releases.
            stall        = 1'b1;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            pend_d       = pend_q | br_taken;
        end else if (br_taken || pend_q) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pend_d     = 1'b0;
        end else if (lu) begin
            stall      = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        sc_d     = (stall && (sc_q != '1)) ? sc_q + 1'b1 : sc_q;
        consec_d = pc_en ? '0 : ((consec_q >= WdogLim) ? consec_q : consec_q + 1'b1);
        hang_d   = hang_q | (consec_d >= WdogLim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pend_q   <= 1'b0;
            sc_q     <= '0;
            consec_q <= '0;
            hang_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            sc_q     <= sc_d;
            consec_q <= consec_d;
            hang_q   <= hang_d;
        end
    end

    // Registered stats read as zero for the whole reset window, including its first cycle.
    assign stall_cycles = rst ? '0 : sc_q;
    assign hang         = rst ? 1'b0 : hang_q;

endmodule
